core_seq_ctrl: RTL and testbench
================================

# core_seq_ctrl

Multi-cycle sequencing controller for the RV32E npc core. It owns the PC and instruction register, fetches over a request/ack handshake, and presents the latched instruction fields to the decoder and immediate extender. It steps the datapath through decode, execute, memory and writeback, and generates the register-file write enable and PC update. It also halts the core on `ebreak`, on an unknown instruction type, or on a memory timeout.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC value loaded at reset.
- `TIMEOUT`, 255, maximum wait cycles for `inst_ack` or `mem_ack` before an error halt (8-bit counter).

Ports:
- `clk` in 1: single core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst_req` out 1: instruction fetch request, address is `pc`.
- `inst_ack` in 1: fetch complete; `inst_rdata` valid this cycle.
- `inst_rdata` in 32: fetched instruction word.
- `pc` out `RegBus`: current PC.
- `ir` out 32: latched instruction; the rs1/rs2/rd/funct3/funct7 fields feed the decoder and immediate extender.
- `type_i` in `TYPE_BUS`: decoded type for `ir` (`INST_R/I/S/B/U/J`).
- `is_load` in 1, `is_store` in 1: memory class of `ir`.
- `is_ebreak` in 1: `ir` is `ebreak`.
- `next_pc` in `RegBus`: PC computed by the EXU.
- `mem_req` out 1, `mem_we` out 1: data memory request; `mem_we`=1 for stores.
- `mem_ack` in 1: data access complete.
- `ex_en` out 1: one-cycle EXU operand/immediate latch strobe.
- `rf_we` out 1: register-file write strobe.
- `retired` out 32: count of retired instructions.
- `halt` out 1, `err` out 1: core halted; `err` marks an abnormal halt.

## Operation
- States: `IDLE`, `FETCH`, `DECODE`, `EXEC`, `MEM`, `WB`, `HALT`.
- `IDLE`: occupied for one cycle after reset release, then moves to `FETCH`.
- `FETCH`:
  - Asserts `inst_req` until the cycle in which `inst_ack`=1.
  - On that cycle, `ir`<=`inst_rdata` and the state moves to `DECODE`.
- `DECODE`: one cycle; samples `type_i`.
  - Type not in {R,I,S,B,U,J}: `err`<=1 and the state moves to `HALT`.
  - Otherwise the state moves to `EXEC`.
- `EXEC`:
  - One cycle with `ex_en`=1.
  - Moves to `MEM` if `is_load|is_store`, else to `WB`.
- `MEM`:
  - Asserts `mem_req` until `mem_ack`; `mem_we`=`is_store`.
  - On ack, moves to `WB`.
- `WB`: one cycle.
  - `rf_we`=1 for types R, I, U, J. Stores and branches (S, B) never write.
  - `pc`<=`next_pc`; `retired`<=`retired`+1 (wraps modulo 2^32).
  - If `is_ebreak`, moves to `HALT` with `err`=0; else moves to `FETCH`.
- `HALT`:
  - Absorbing state; `halt`=1.
  - No `inst_req`, `mem_req` or `rf_we`; exited only by reset.
- Wait counter:
  - Cleared on entry to `FETCH` or `MEM`; increments each cycle the ack is low.
  - When it reaches `TIMEOUT` with the ack still low: `err`<=1, state moves to `HALT`, and the request drops the next cycle.
  - An ack arriving on the same cycle the counter reaches `TIMEOUT` wins; no error is raised.
- Acks arriving outside `FETCH`/`MEM` are ignored.
- `ir` and `pc` change only as described above.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - State `IDLE`, `pc`=`RESET_PC`, `ir`=32'h0000_0013 (nop).
  - `retired`=0, `counter`=0.
  - All strobes 0, `halt`=0, `err`=0.
- Reset asserted mid-operation aborts any outstanding request immediately; `inst_req`/`mem_req` fall asynchronously.
- All outputs are registered or decoded from the state register only; there is no combinational path from `*_ack` to `*_req`.
- Minimum instruction latency, with ack in the first request cycle:
  - 4 cycles for non-memory instructions (FETCH, DECODE, EXEC, WB).
  - 5 cycles for loads and stores.
- `inst_req` is first asserted one cycle after `rst_n` rises (the `IDLE` cycle).
- `rf_we` and the `pc` update occur in the same `WB` cycle; the new `pc` is visible in the first `FETCH` cycle.

## Test plan
- Reset, then `inst_ack` on the first request with `addi` (type I) and `next_pc`=0x8000_0004 → `rf_we` pulses in cycle 4, `pc`=0x8000_0004, `retired`=1.
- `sw` (type S, `is_store`) with `mem_ack` delayed 3 cycles → `mem_req`/`mem_we` high for 4 cycles, `rf_we` stays 0, instruction retires after 8 cycles.
- `beq` (type B), `next_pc`=0x8000_0100 → no `rf_we`; the next `inst_req` has `pc`=0x8000_0100.
- `ebreak` → `halt`=1, `err`=0, `retired` incremented, no further `inst_req` over 20 cycles.
- `inst_ack` held low with `TIMEOUT`=4 → `halt`=1 and `err`=1 after 4 wait cycles; `inst_ack`=1 on exactly the 4th cycle instead → normal decode.
- Unknown `type_i` → `err`=1, `halt`=1. Then pull `rst_n` low during `MEM` → `mem_req` drops immediately; after release, `pc`=`RESET_PC` and the sequence restarts from `IDLE`.

Source files
------------

// File: rtl/core_seq_ctrl_if.sv
// core_seq_ctrl_if
// Groups the fetch and data-memory handshakes of the sequencing controller.
//   inst_req   : instruction fetch request (address is the controller's pc)
//   inst_ack   : fetch complete, inst_rdata valid this cycle
//   inst_rdata : fetched instruction word
//   mem_req    : data memory request
//   mem_we     : data memory write (store)
//   mem_ack    : data access complete
// master = controller side, slave = memory side.
interface core_seq_ctrl_if;
    logic        inst_req;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;

    modport master (
        output inst_req,
        output mem_req,
        output mem_we,
        input  inst_ack,
        input  inst_rdata,
        input  mem_ack
    );

    modport slave (
        input  inst_req,
        input  mem_req,
        input  mem_we,
        output inst_ack,
        output inst_rdata,
        output mem_ack
    );
endinterface

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl
// Multi-cycle sequencing controller for the RV32E npc core. Owns pc and the
// instruction register, steps the datapath FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// and halts on ebreak, an unknown instruction type, or a handshake timeout.
// Ports:
//   clk, rst_n       : core clock (rising edge), asynchronous active-low reset
//   bus              : fetch / data-memory handshakes (core_seq_ctrl_if.master)
//   pc, ir           : current PC and latched instruction
//   type_i           : decoded type of ir (INST_R/I/S/B/U/J)
//   is_load/is_store : memory class of ir
//   is_ebreak        : ir is ebreak
//   next_pc          : PC computed by the EXU
//   ex_en            : one-cycle EXU operand/immediate latch strobe
//   rf_we            : register-file write strobe
//   retired          : retired instruction count
//   halt, err        : core halted / abnormal halt
module core_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    core_seq_ctrl_if.master        bus,
    output logic [31:0]            pc,
    output logic [31:0]            ir,
    input  logic [2:0]             type_i,
    input  logic                   is_load,
    input  logic                   is_store,
    input  logic                   is_ebreak,
    input  logic [31:0]            next_pc,
    output logic                   ex_en,
    output logic                   rf_we,
    output logic [31:0]            retired,
    output logic                   halt,
    output logic                   err
);
    // Instruction type encoding; 0 and 7 are not valid types.
    localparam logic [2:0] INST_R = 3'd1;
    localparam logic [2:0] INST_I = 3'd2;
    localparam logic [2:0] INST_S = 3'd3;
    localparam logic [2:0] INST_B = 3'd4;
    localparam logic [2:0] INST_U = 3'd5;
    localparam logic [2:0] INST_J = 3'd6;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // A low ack seen while the counter holds this value is the TIMEOUT-th wait cycle.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic        type_valid;
    logic        type_writes;

    assign type_valid  = type_i inside {INST_R, INST_I, INST_S, INST_B, INST_U, INST_J};
    assign type_writes = type_i inside {INST_R, INST_I, INST_U, INST_J};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            ir_q      <= NOP;
            retired_q <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        err_d     = err_q;
        // Counter is zero in every non-waiting state, so it starts cleared on entry.
        wait_d    = '0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (bus.inst_ack) begin
                    ir_d    = bus.inst_rdata;
                    state_d = StDecode;
                end else if (wait_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDecode: begin
                if (type_valid) begin
                    state_d = StExec;
                end else begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end
            end
            StExec: state_d = (is_load || is_store) ? StMem : StWb;
            StMem: begin
                if (bus.mem_ack) begin
                    state_d = StWb;
                end else if (wait_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StWb: begin
                pc_d      = next_pc;
                retired_d = retired_q + 32'd1;
                state_d   = is_ebreak ? StHalt : StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    // Strobes decode from the state register only, so reset drops requests asynchronously.
    assign bus.inst_req = (state_q == StFetch);
    assign bus.mem_req  = (state_q == StMem);
    assign bus.mem_we   = (state_q == StMem) && is_store;
    assign ex_en        = (state_q == StExec);
    assign rf_we        = (state_q == StWb) && type_writes;
    assign halt         = (state_q == StHalt);
    assign err          = err_q;
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign retired      = retired_q;
endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int unsigned TIMEOUT  = 4;
    localparam logic [2:0] INST_R = 3'd1;
    localparam logic [2:0] INST_I = 3'd2;
    localparam logic [2:0] INST_S = 3'd3;
    localparam logic [2:0] INST_B = 3'd4;
    localparam logic [2:0] INST_U = 3'd5;
    localparam logic [2:0] INST_J = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc, ir, next_pc, retired;
    logic [2:0]  type_i;
    logic        is_load, is_store, is_ebreak, ex_en, rf_we, halt, err;

    core_seq_ctrl_if bus ();

    core_seq_ctrl #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .pc        (pc),
        .ir        (ir),
        .type_i    (type_i),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_ebreak (is_ebreak),
        .next_pc   (next_pc),
        .ex_en     (ex_en),
        .rf_we     (rf_we),
        .retired   (retired),
        .halt      (halt),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  ty;
        logic        ld, st, eb;
        logic [31:0] npc;
        int          fd, md;
    } txn_t;

    typedef struct {
        logic [31:0] rdata, npc;
        int          lat, req_cyc, mem_cyc, we_cyc, rf_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int          cyc = 0, start = 0, req_c = 0, mem_c = 0, we_c = 0, rf_c = 0, ex_c = 0;
    logic        in_inst = 1'b0;
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] last_ret = '0;
    logic [31:0] exp_ret = '0;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_inst  = 1'b0;
            model_pc = RESET_PC;
            last_ret = '0;
            exp_ret  = '0;
        end else begin
            cyc++;
            if (retired !== last_ret) begin
                last_ret = retired;
                if (sb_q.size() == 0) begin
                    check("unexpected retire", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    exp_ret  = exp_ret + 32'd1;
                    model_pc = e.npc;
                    check("retired count", retired, exp_ret);
                    check("pc after wb", pc, model_pc);
                    check("ir", ir, e.rdata);
                    check("latency", 32'(cyc - start), 32'(e.lat));
                    check("inst_req cycles", 32'(req_c), 32'(e.req_cyc));
                    check("mem_req cycles", 32'(mem_c), 32'(e.mem_cyc));
                    check("mem_we cycles", 32'(we_c), 32'(e.we_cyc));
                    check("rf_we cycles", 32'(rf_c), 32'(e.rf_cyc));
                    check("ex_en cycles", 32'(ex_c), 32'd1);
                end
                in_inst = 1'b0;
            end
            if (bus.inst_req && !in_inst) begin
                in_inst = 1'b1;
                start = cyc;
                req_c = 0; mem_c = 0; we_c = 0; rf_c = 0; ex_c = 0;
                check("fetch pc", pc, model_pc);
            end
            if (in_inst) begin
                req_c += int'(bus.inst_req);
                mem_c += int'(bus.mem_req);
                we_c  += int'(bus.mem_req && bus.mem_we);
                rf_c  += int'(rf_we);
                ex_c  += int'(ex_en);
            end
        end
    end

    // ---------------- driver ----------------
    // Waits (at negedges) for a request; meanwhile toggles the other ack, which must be ignored.
    task automatic wait_req(input bit mem, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!(mem ? bus.mem_req : bus.inst_req)) begin
            if (mem) bus.inst_ack = 1'($urandom_range(0, 1));
            else     bus.mem_ack  = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
            if (n > 50) begin
                check(mem ? "mem_req wait" : "inst_req wait", 32'd0, 32'd1);
                ok = 1'b0;
                break;
            end
        end
        bus.inst_ack = 1'b0;
        bus.mem_ack  = 1'b0;
    endtask

    task automatic run_inst(input txn_t t, input bit push);
        bit   ok;
        bit   mem;
        exp_t x;
        mem = t.ld || t.st;
        wait_req(1'b0, ok);
        if (!ok) return;
        repeat (t.fd) @(negedge clk);
        bus.inst_ack   = 1'b1;
        bus.inst_rdata = t.rdata;
        type_i         = t.ty;
        is_load        = t.ld;
        is_store       = t.st;
        is_ebreak      = t.eb;
        next_pc        = t.npc;
        if (push) begin
            x.rdata   = t.rdata;
            x.npc     = t.npc;
            x.req_cyc = t.fd + 1;
            x.mem_cyc = mem ? t.md + 1 : 0;
            x.we_cyc  = t.st ? t.md + 1 : 0;
            x.rf_cyc  = (t.ty == INST_S || t.ty == INST_B) ? 0 : 1;
            x.lat     = 4 + t.fd + (mem ? t.md + 1 : 0);
            sb_q.push_back(x);
        end
        @(negedge clk);
        bus.inst_ack = 1'b0;
        if (mem) begin
            wait_req(1'b1, ok);
            if (!ok) return;
            repeat (t.md) @(negedge clk);
            bus.mem_ack = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
    endtask

    function automatic txn_t mk(input logic [2:0] ty, input logic ld, input logic st,
                                input logic eb, input logic [31:0] npc, input int fd,
                                input int md);
        txn_t t;
        t.rdata = $urandom;
        t.ty = ty; t.ld = ld; t.st = st; t.eb = eb; t.npc = npc; t.fd = fd; t.md = md;
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.inst_ack = 1'b0;
        bus.mem_ack  = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        txn_t t;
        int   n_ret;
        int   cnt;
        int   reqs;
        logic [2:0] tys [6] = '{INST_R, INST_I, INST_S, INST_B, INST_U, INST_J};

        bus.inst_ack = 1'b0; bus.mem_ack = 1'b0; bus.inst_rdata = '0;
        type_i = INST_I; is_load = 1'b0; is_store = 1'b0; is_ebreak = 1'b0; next_pc = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset pc", pc, RESET_PC);
        check("reset ir", ir, 32'h0000_0013);
        check("reset retired", retired, 32'd0);
        check("reset strobes", 32'({bus.inst_req, bus.mem_req, bus.mem_we, ex_en, rf_we}), 32'd0);
        check("reset halt/err", 32'({halt, err}), 32'd0);
        rst_n = 1'b1;
        #1 check("inst_req in idle", 32'(bus.inst_req), 32'd0);

        // Directed: addi, sw with 3-cycle mem delay, beq
        n_ret = 0;
        run_inst(mk(INST_I, 1'b0, 1'b0, 1'b0, 32'h8000_0004, 0, 0), 1'b1); n_ret++;
        run_inst(mk(INST_S, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 0, 3), 1'b1); n_ret++;
        run_inst(mk(INST_B, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 0, 0), 1'b1); n_ret++;

        // Random instruction stream
        for (int i = 0; i < 40; i++) begin
            logic [2:0] ty;
            logic ld, st;
            ty = tys[$urandom_range(0, 5)];
            ld = (ty == INST_I) && ($urandom_range(0, 1) == 1);
            st = (ty == INST_S);
            run_inst(mk(ty, ld, st, 1'b0, {$urandom} & 32'hffff_fffc,
                        $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1)), 1'b1);
            n_ret++;
        end

        // ebreak halts cleanly, retires, and issues no further fetches
        run_inst(mk(INST_I, 1'b0, 1'b0, 1'b1, 32'h8000_1000, 1, 0), 1'b1); n_ret++;
        cnt = 0;
        while (!halt && cnt < 20) begin @(negedge clk); cnt++; end
        check("ebreak halt", 32'(halt), 32'd1);
        check("ebreak err", 32'(err), 32'd0);
        check("ebreak retired", retired, 32'(n_ret));
        reqs = 0;
        repeat (20) begin @(negedge clk); reqs += int'(bus.inst_req); end
        check("no fetch after halt", 32'(reqs), 32'd0);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        // Fetch timeout: ack held low
        do_reset();
        begin
            bit ok;
            wait_req(1'b0, ok);
        end
        cnt = 0;
        while (bus.inst_req && cnt < 20) begin cnt++; @(negedge clk); end
        check("timeout req cycles", 32'(cnt), 32'(TIMEOUT));
        check("timeout halt", 32'(halt), 32'd1);
        check("timeout err", 32'(err), 32'd1);
        check("timeout retired", retired, 32'd0);

        // Ack on exactly the TIMEOUT-th cycle wins
        do_reset();
        run_inst(mk(INST_R, 1'b0, 1'b0, 1'b0, 32'h8000_0040, TIMEOUT - 1, 0), 1'b1);
        cnt = 0;
        while (retired != 32'd1 && cnt < 10) begin @(negedge clk); cnt++; end
        check("boundary ack retired", retired, 32'd1);
        check("boundary ack err", 32'(err), 32'd0);
        check("boundary ack halt", 32'(halt), 32'd0);

        // Unknown type halts with error and retires nothing
        run_inst(mk(3'd7, 1'b0, 1'b0, 1'b0, 32'h8000_0080, 0, 0), 1'b0);
        cnt = 0;
        while (!halt && cnt < 10) begin @(negedge clk); cnt++; end
        check("unknown type halt", 32'(halt), 32'd1);
        check("unknown type err", 32'(err), 32'd1);
        check("unknown type retired", retired, 32'd1);
        check("unknown type pc", pc, 32'h8000_0040);

        // Reset asserted during MEM drops mem_req asynchronously
        do_reset();
        begin
            bit ok;
            wait_req(1'b0, ok);
            bus.inst_ack = 1'b1; bus.inst_rdata = 32'h00a1_2023;
            type_i = INST_S; is_store = 1'b1; is_load = 1'b0; is_ebreak = 1'b0;
            next_pc = 32'h8000_0004;
            @(negedge clk);
            bus.inst_ack = 1'b0;
            wait_req(1'b1, ok);
        end
        check("mem_req before reset", 32'(bus.mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mem_req async drop", 32'(bus.mem_req), 32'd0);
        check("mem_we async drop", 32'(bus.mem_we), 32'd0);
        check("pc after reset", pc, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle after release", 32'(bus.inst_req), 32'd0);
        @(negedge clk);
        check("fetch after idle", 32'(bus.inst_req), 32'd1);
        check("restart pc", pc, RESET_PC);
        check("restart ir", ir, 32'h0000_0013);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
